traffic_safety_mon: RTL
=======================

# traffic_safety_mon

Conflict monitor that sits directly downstream of the four-approach intersection controller. It consumes the eight 2-bit lamp codes and the 7-bit cycle count, and re-registers them as the lamp-driver outputs. It forces all-red on any suspected conflict and latches a fault with car-yellow flashing once the conflict is confirmed. Conflicting codes never reach its outputs.

## Interface
- CONFIRM, 2: consecutive conflicting samples required to latch a fault (≥1).
- FLASH_HALF, 4: clock cycles per half-period of fault flashing.
- MIN_FAULT, 16: minimum cycles in FAULT before i_clear is accepted.
- CYC_MAX, 68: last value of the upstream cycle count; the count runs 1..CYC_MAX.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  upstream count-enable; the same signal that drives the controller.
- i_clear  in  1  operator fault-clear pulse.
- i_cycle  in  7  upstream cycle count.
- i_n_car, i_n_ped, i_s_car, i_s_ped, i_e_car, i_e_ped, i_w_car, i_w_ped  in  2 each  upstream codes: 00 red, 01 green, 10 right/yellow, 11 left.
- o_n_car … o_w_ped  out  2 each  safe lamp codes, same encoding, registered.
- o_fault  out  1  high while in FAULT.
- o_fault_code  out  3  latched cause: 0 none, 1 axis, 2 ped, 3 pair, 4 sequence.
- o_state  out  2  0 IDLE, 1 RUN, 2 SUSPECT, 3 FAULT.

## Operation
Conflict rules are evaluated on the current inputs. When several fire, the lowest code wins.
- Rule 1, axis: (n_car|s_car non-red) and (e_car|w_car non-red).
- Rule 2, ped: any car non-red while the ped of the same axis is non-red (N/S cars vs N/S peds; E/W cars vs E/W peds).
- Rule 3, pair: n_car≠s_car, n_ped≠s_ped, e_car≠w_car, or e_ped≠w_ped.
- Rule 4, sequence: only when prev_valid is set.
  - i_cycle must be within 1..CYC_MAX.
  - If i_start=1: i_cycle must equal prev+1, or 1 when prev=CYC_MAX.
  - If i_start=0: i_cycle must equal prev.
  - prev is the previous sampled i_cycle. prev_valid is set on every RUN/SUSPECT cycle and cleared in IDLE/FAULT.

FSM:
- IDLE: outputs all 00; no checks. i_start=1 → RUN.
- RUN: outputs take the inputs.
  - Conflict → SUSPECT with cnt=1; if CONFIRM=1, go directly to FAULT.
  - i_start falling stays in RUN; the frozen count is checked via Rule 4.
- SUSPECT: outputs all 00.
  - Conflict → cnt+1; at cnt=CONFIRM → FAULT.
  - No conflict → RUN, cnt=0.
- FAULT:
  - o_fault=1; o_fault_code is latched from the code on the entry edge.
  - Peds 00. Cars all 10 when phase=1, 00 when phase=0. phase=1 on entry and toggles every FLASH_HALF cycles.
  - Fault timer saturates at MIN_FAULT. i_clear while timer=MIN_FAULT → IDLE, o_fault_code←0. i_clear earlier is ignored.
  - Inputs are ignored throughout.

## Timing
- Reset (asynchronous, any state): all lamp outputs 00, o_fault 0, o_fault_code 0, o_state IDLE. All counters, phase and prev_valid cleared.
- Latency: one clock. Outputs at edge k+1 reflect inputs sampled at edge k.
- A conflict sampled at edge k forces all-red at edge k; the conflicting code is never output.
- With CONFIRM=2, a conflict sampled at k and k+1 asserts o_fault after edge k+1.
- A conflict present for 1 sample (CONFIRM>1) produces exactly one all-red cycle, then pass-through resumes.
- Simultaneous i_clear and a conflict in FAULT: clear wins → IDLE. Checks restart from RUN with prev_valid=0.
- Counter widths are $clog2 of parameter+1, saturating, never wrapping.

## Structure
- Package traffic_pkg holds the lamp-code constants (RED, GREEN, RIGHT, LEFT), the state enum, the fault-code constants and CYC_MAX. It is shared with the controller.
- Sub-module traffic_conflict_chk: combinational rule evaluation with the priority encoder, outputting conflict and code[2:0]. The top keeps the FSM, counters and output registers.

## Test plan
- Legal full cycle: 68-cycle normal sequence from the controller with i_start=1 → outputs equal the inputs delayed 1 clock; o_state=RUN throughout; o_fault=0.
- Axis conflict, 2 cycles: n_car=01 and e_car=01 on two samples → all-red at the first edge; o_fault=1 and o_fault_code=1 at the second; cars 10/00 toggle every 4 cycles.
- Glitch: n_ped=01 with n_car=01 for 1 sample → one all-red cycle, then RUN; o_fault stays 0.
- Sequence: i_cycle 5 → 7 with i_start=1, held 2 cycles → fault code 4. Separately, i_cycle 68 → 1 → no fault. i_start=0 with i_cycle held → no fault.
- Clear: i_clear at fault-timer 10 → ignored. i_clear at ≥16 → IDLE, outputs 00, code 0; i_start=1 → RUN.
- Reset mid-SUSPECT and mid-FAULT: assert rst asynchronously → all outputs 00, IDLE, immediately without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller and its safety monitor.
package traffic_pkg;

  localparam logic [1:0] RED   = 2'b00;
  localparam logic [1:0] GREEN = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;

  localparam int unsigned CYC_MAX = 68;

  localparam logic [2:0] FC_NONE = 3'd0;
  localparam logic [2:0] FC_AXIS = 3'd1;
  localparam logic [2:0] FC_PED  = 3'd2;
  localparam logic [2:0] FC_PAIR = 3'd3;
  localparam logic [2:0] FC_SEQ  = 3'd4;

  // Lamp vector order: n_car, n_ped, s_car, s_ped, e_car, e_ped, w_car, w_ped (MSB first)
  localparam logic [15:0] FLASH_LAMPS = {RIGHT, RED, RIGHT, RED, RIGHT, RED, RIGHT, RED};

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StSuspect = 2'd2,
    StFault   = 2'd3
  } state_e;

endpackage

// File: rtl/traffic_conflict_chk.sv
// Combinational conflict rules with lowest-code-wins priority.
module traffic_conflict_chk #(
  parameter int unsigned CYC_MAX = traffic_pkg::CYC_MAX
) (
  input  logic [1:0] n_car,
  input  logic [1:0] n_ped,
  input  logic [1:0] s_car,
  input  logic [1:0] s_ped,
  input  logic [1:0] e_car,
  input  logic [1:0] e_ped,
  input  logic [1:0] w_car,
  input  logic [1:0] w_ped,
  input  logic       start,
  input  logic [6:0] cycle,
  input  logic [6:0] prev_cycle,
  input  logic       prev_valid,
  output logic       conflict,
  output logic [2:0] code
);
  import traffic_pkg::*;

  localparam logic [6:0] CYC_MAX_C = 7'(CYC_MAX);

  logic ns_car, ew_car, ns_ped, ew_ped;
  logic axis_bad, ped_bad, pair_bad, seq_bad;
  logic [6:0] next_cycle;

  assign ns_car = (|n_car) || (|s_car);
  assign ew_car = (|e_car) || (|w_car);
  assign ns_ped = (|n_ped) || (|s_ped);
  assign ew_ped = (|e_ped) || (|w_ped);

  assign axis_bad = ns_car && ew_car;
  assign ped_bad  = (ns_car && ns_ped) || (ew_car && ew_ped);
  assign pair_bad = (n_car != s_car) || (n_ped != s_ped) || (e_car != w_car) || (e_ped != w_ped);

  assign next_cycle = (prev_cycle == CYC_MAX_C) ? 7'd1 : prev_cycle + 7'd1;
  assign seq_bad = prev_valid &&
                   ((cycle == 7'd0) || (cycle > CYC_MAX_C) ||
                    (start ? (cycle != next_cycle) : (cycle != prev_cycle)));

  always_comb begin
    conflict = 1'b1;
    code     = FC_NONE;
    if (axis_bad) begin
      code = FC_AXIS;
    end else if (ped_bad) begin
      code = FC_PED;
    end else if (pair_bad) begin
      code = FC_PAIR;
    end else if (seq_bad) begin
      code = FC_SEQ;
    end else begin
      conflict = 1'b0;
    end
  end

endmodule

// File: rtl/traffic_safety_mon.sv
// Conflict monitor: re-registers lamp codes, forces all-red on suspicion, latches flashing fault.
module traffic_safety_mon #(
  parameter int unsigned CONFIRM    = 2,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned MIN_FAULT  = 16,
  parameter int unsigned CYC_MAX    = traffic_pkg::CYC_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_clear,
  input  logic [6:0] i_cycle,
  input  logic [1:0] i_n_car,
  input  logic [1:0] i_n_ped,
  input  logic [1:0] i_s_car,
  input  logic [1:0] i_s_ped,
  input  logic [1:0] i_e_car,
  input  logic [1:0] i_e_ped,
  input  logic [1:0] i_w_car,
  input  logic [1:0] i_w_ped,
  output logic [1:0] o_n_car,
  output logic [1:0] o_n_ped,
  output logic [1:0] o_s_car,
  output logic [1:0] o_s_ped,
  output logic [1:0] o_e_car,
  output logic [1:0] o_e_ped,
  output logic [1:0] o_w_car,
  output logic [1:0] o_w_ped,
  output logic       o_fault,
  output logic [2:0] o_fault_code,
  output logic [1:0] o_state
);
  import traffic_pkg::*;

  localparam int unsigned CW = $clog2(CONFIRM + 1);
  localparam int unsigned FW = $clog2(FLASH_HALF + 1);
  localparam int unsigned TW = $clog2(MIN_FAULT + 1);
  localparam logic [CW-1:0] CONFIRM_C  = CW'(CONFIRM);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
  localparam logic [TW-1:0] MIN_FAULT_C = TW'(MIN_FAULT);

  state_e        state_q;
  logic [15:0]   lamp_q;
  logic [2:0]    fault_code_q;
  logic [CW-1:0] cnt_q;
  logic [FW-1:0] flash_q;
  logic [TW-1:0] timer_q;
  logic          phase_q;
  logic [6:0]    prev_q;
  logic          prev_valid_q;

  logic [15:0] lamp_in;
  logic        conflict;
  logic [2:0]  code;

  assign lamp_in = {i_n_car, i_n_ped, i_s_car, i_s_ped, i_e_car, i_e_ped, i_w_car, i_w_ped};

  traffic_conflict_chk #(
    .CYC_MAX(CYC_MAX)
  ) u_chk (
    .n_car     (i_n_car),
    .n_ped     (i_n_ped),
    .s_car     (i_s_car),
    .s_ped     (i_s_ped),
    .e_car     (i_e_car),
    .e_ped     (i_e_ped),
    .w_car     (i_w_car),
    .w_ped     (i_w_ped),
    .start     (i_start),
    .cycle     (i_cycle),
    .prev_cycle(prev_q),
    .prev_valid(prev_valid_q),
    .conflict  (conflict),
    .code      (code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      lamp_q       <= '0;
      fault_code_q <= FC_NONE;
      cnt_q        <= '0;
      flash_q      <= '0;
      timer_q      <= '0;
      phase_q      <= 1'b0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          lamp_q       <= '0;
          prev_valid_q <= 1'b0;
          cnt_q        <= '0;
          if (i_start) state_q <= StRun;
        end
        StRun, StSuspect: begin
          prev_q       <= i_cycle;
          prev_valid_q <= 1'b1;
          if (!conflict) begin
            state_q <= StRun;
            cnt_q   <= '0;
            lamp_q  <= lamp_in;
          end else if (cnt_q + 1'b1 == CONFIRM_C) begin
            state_q      <= StFault;
            fault_code_q <= code;
            cnt_q        <= '0;
            flash_q      <= '0;
            timer_q      <= '0;
            phase_q      <= 1'b1;
            lamp_q       <= FLASH_LAMPS;
          end else begin
            // The suspected code is never passed through.
            state_q <= StSuspect;
            cnt_q   <= cnt_q + 1'b1;
            lamp_q  <= '0;
          end
        end
        StFault: begin
          prev_valid_q <= 1'b0;
          if (timer_q != MIN_FAULT_C) timer_q <= timer_q + 1'b1;
          if (i_clear && (timer_q == MIN_FAULT_C)) begin
            state_q      <= StIdle;
            fault_code_q <= FC_NONE;
            lamp_q       <= '0;
            timer_q      <= '0;
            flash_q      <= '0;
            phase_q      <= 1'b0;
          end else if (flash_q == FLASH_LAST) begin
            flash_q <= '0;
            phase_q <= ~phase_q;
            lamp_q  <= phase_q ? '0 : FLASH_LAMPS;
          end else begin
            flash_q <= flash_q + 1'b1;
            lamp_q  <= phase_q ? FLASH_LAMPS : '0;
          end
        end
      endcase
    end
  end

  assign {o_n_car, o_n_ped, o_s_car, o_s_ped, o_e_car, o_e_ped, o_w_car, o_w_ped} = lamp_q;
  assign o_fault      = (state_q == StFault);
  assign o_fault_code = fault_code_q;
  assign o_state      = state_q;

endmodule
